// File: rtl/delay_meter_pkg.sv
// delay_meter_pkg: shared states, result constants and default parameters for delay_meter.
package delay_meter_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, HOLD} state_t;

    localparam logic RISE = 1'b1;
    localparam logic FALL = 1'b0;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_TIMEOUT    = 1000;
    localparam bit DEF_AUTO_REARM = 1'b0;

endpackage

// File: rtl/edge_det.sv
// edge_det: registers a level and flags the cycle in which a change is first sampled.
module edge_det
    import delay_meter_pkg::*;
(
    input  logic clk,
    input  logic d,
    output logic chg,
    output logic lvl
);

    logic q;

    // Loading the live level every cycle, reset included, means no false edge follows reset.
    always_ff @(posedge clk) q <= d;

    assign chg = d != q;
    assign lvl = d;

endmodule

// File: rtl/delay_meter.sv
// delay_meter: measures clk-tick distance from a stim edge to the following resp edge
// and reports it through a valid/ready result port.
module delay_meter
    import delay_meter_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter bit AUTO_REARM = DEF_AUTO_REARM
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             stim,
    input  logic             resp,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_delay,
    output logic             res_rise,
    output logic             res_timeout,
    output logic             res_glitch
);

    if (TIMEOUT > 2**CNT_W - 1) begin : g_bad_timeout
        $error("delay_meter: TIMEOUT does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic             glitch, s_chg, r_chg, r_lvl, unused_s_lvl, take, done;

    edge_det u_stim (.clk(clk), .d(stim), .chg(s_chg), .lvl(unused_s_lvl));
    edge_det u_resp (.clk(clk), .d(resp), .chg(r_chg), .lvl(r_lvl));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = arm ? ARMED : IDLE;
            ARMED:   state_n = !s_chg ? ARMED : r_chg ? HOLD : MEASURE;
            MEASURE: state_n = (r_chg || cnt == TMO) ? HOLD : MEASURE;
            default: state_n = res_ready ? (AUTO_REARM ? ARMED : IDLE) : HOLD;
        endcase
    end

    assign take = state != HOLD && state_n == HOLD;
    assign done = state == HOLD && res_ready;
    assign busy = state == ARMED || state == MEASURE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            glitch      <= 1'b0;
            res_valid   <= 1'b0;
            res_delay   <= '0;
            res_rise    <= 1'b0;
            res_timeout <= 1'b0;
            res_glitch  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= state_n != MEASURE ? '0 : state == MEASURE ? cnt + 1'b1 : CNT_W'(1);
            glitch <= state == MEASURE && (glitch || s_chg);
            // A resp edge wins over a timeout landing in the same cycle.
            if (take) begin
                res_valid   <= 1'b1;
                res_delay   <= state == ARMED ? '0 : r_chg ? cnt : TMO;
                res_rise    <= r_chg ? r_lvl : FALL;
                res_timeout <= !r_chg;
                res_glitch  <= glitch || (state == MEASURE && s_chg);
            end else if (done) begin
                res_valid   <= 1'b0;
                res_delay   <= '0;
                res_rise    <= 1'b0;
                res_timeout <= 1'b0;
                res_glitch  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_delay_meter.sv
// tb_delay_meter: scoreboard bench for delay_meter, one manual-arm instance and one auto-rearm instance.
module tb_delay_meter;
    import delay_meter_pkg::*;

    typedef struct packed {
        logic [15:0] d;
        logic        r;
        logic        t;
        logic        g;
    } res_t;

    logic clk = 1'b0, reset = 1'b1;
    logic arm1 = 1'b0, stim1 = 1'b1, resp1 = 1'b0, rdy1 = 1'b0;
    logic arm2 = 1'b0, stim2 = 1'b0, resp2 = 1'b0, rdy2 = 1'b1;
    logic v1, busy1, r1, t1, g1, v2, busy2, r2, t2, g2;
    logic [15:0] d1, d2;

    int checks = 0, errors = 0;
    res_t q1[$], q2[$];
    res_t e1, e2;

    always #5 clk = ~clk;

    delay_meter #(.CNT_W(16), .TIMEOUT(50), .AUTO_REARM(1'b0)) dut (
        .clk(clk), .reset(reset), .arm(arm1), .stim(stim1), .resp(resp1), .busy(busy1),
        .res_valid(v1), .res_ready(rdy1), .res_delay(d1), .res_rise(r1),
        .res_timeout(t1), .res_glitch(g1)
    );

    delay_meter #(.CNT_W(16), .TIMEOUT(50), .AUTO_REARM(1'b1)) dut_ar (
        .clk(clk), .reset(reset), .arm(arm2), .stim(stim2), .resp(resp2), .busy(busy2),
        .res_valid(v2), .res_ready(rdy2), .res_delay(d2), .res_rise(r2),
        .res_timeout(t2), .res_glitch(g2)
    );

    always @(negedge clk) begin
        if (v1 && rdy1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut_result unexpected delay=%0d rise=%0d tmo=%0d glitch=%0d", d1, r1, t1, g1);
            end else begin
                e1 = q1.pop_front();
                if ({d1, r1, t1, g1} !== e1) begin
                    errors++;
                    $display("FAIL dut_result got delay=%0d rise=%0d tmo=%0d glitch=%0d expected delay=%0d rise=%0d tmo=%0d glitch=%0d",
                             d1, r1, t1, g1, e1.d, e1.r, e1.t, e1.g);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (v2 && rdy2) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL ar_result unexpected delay=%0d rise=%0d tmo=%0d glitch=%0d", d2, r2, t2, g2);
            end else begin
                e2 = q2.pop_front();
                if ({d2, r2, t2, g2} !== e2) begin
                    errors++;
                    $display("FAIL ar_result got delay=%0d rise=%0d tmo=%0d glitch=%0d expected delay=%0d rise=%0d tmo=%0d glitch=%0d",
                             d2, r2, t2, g2, e2.d, e2.r, e2.t, e2.g);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic arm_1();
        tick(1);
        arm1 = 1'b1;
        tick(1);
        arm1 = 1'b0;
    endtask

    task automatic handshake_1();
        tick(1);
        rdy1 = 1'b1;
        tick(1);
        rdy1 = 1'b0;
        @(negedge clk);
        chk("clr_valid", 32'(v1), 0);
        chk("clr_fields", 32'({d1, r1, t1, g1}), 0);
    endtask

    initial begin
        int dl[3] = '{3, 7, 1};
        tick(3);
        reset = 1'b0;
        tick(1);
        @(negedge clk);
        chk("rst_valid", 32'(v1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_delay", 32'(d1), 0);
        chk("rst_flags", 32'({r1, t1, g1}), 0);

        // fall-to-rise, delay 12, held 5 cycles without ready
        arm_1();
        q1.push_back(res_t'{16'd12, 1'b1, 1'b0, 1'b0});
        stim1 = 1'b0;
        tick(12);
        resp1 = 1'b1;
        tick(1);
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", 32'(v1), 1);
            chk("hold_delay", 32'(d1), 12);
            chk("hold_rise", 32'(r1), 1);
        end
        handshake_1();

        // ready without valid does nothing
        tick(1);
        rdy1 = 1'b1;
        tick(2);
        rdy1 = 1'b0;
        @(negedge clk);
        chk("idle_ready_valid", 32'(v1), 0);

        // zero delay, falling resp: result straight from ARMED
        arm_1();
        q1.push_back(res_t'{16'd0, 1'b0, 1'b0, 1'b0});
        stim1 = 1'b1;
        resp1 = 1'b0;
        tick(1);
        @(negedge clk);
        chk("zero_valid_now", 32'(v1), 1);
        chk("zero_busy", 32'(busy1), 0);
        handshake_1();

        // timeout after 50 cycles, late resp edge ignored
        arm_1();
        q1.push_back(res_t'{16'd50, 1'b0, 1'b1, 1'b0});
        stim1 = 1'b0;
        tick(1);
        tick(49);
        @(negedge clk);
        chk("tmo_early_valid", 32'(v1), 0);
        tick(1);
        @(negedge clk);
        chk("tmo_valid", 32'(v1), 1);
        chk("tmo_flag", 32'(t1), 1);
        tick(1);
        resp1 = 1'b1;
        tick(3);
        handshake_1();

        // glitch: second stim toggle 3 cycles in, resp 10 cycles after first stim edge
        arm_1();
        q1.push_back(res_t'{16'd10, 1'b0, 1'b0, 1'b1});
        stim1 = 1'b1;
        tick(3);
        stim1 = 1'b0;
        tick(7);
        resp1 = 1'b0;
        tick(1);
        handshake_1();

        // glitch does not carry into the next measurement
        arm_1();
        q1.push_back(res_t'{16'd4, 1'b1, 1'b0, 1'b0});
        stim1 = 1'b1;
        tick(4);
        resp1 = 1'b1;
        tick(1);
        handshake_1();

        // reset mid-measure at count 4, levels change under reset
        arm_1();
        stim1 = 1'b0;
        tick(4);
        @(negedge clk);
        chk("mid_busy", 32'(busy1), 1);
        reset = 1'b1;
        stim1 = 1'b1;
        resp1 = 1'b0;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(v1), 0);
        chk("midrst_busy", 32'(busy1), 0);
        chk("midrst_fields", 32'({d1, r1, t1, g1}), 0);
        tick(1);
        stim1 = 1'b0;
        tick(3);
        @(negedge clk);
        chk("idle_stim_valid", 32'(v1), 0);
        chk("idle_stim_busy", 32'(busy1), 0);
        arm_1();
        tick(3);
        @(negedge clk);
        chk("armed_busy", 32'(busy1), 1);
        chk("armed_no_result", 32'(v1), 0);
        tick(1);
        q1.push_back(res_t'{16'd2, 1'b1, 1'b0, 1'b0});
        stim1 = 1'b1;
        tick(2);
        resp1 = 1'b1;
        tick(1);
        handshake_1();

        // auto re-arm: three results, one arm
        tick(1);
        arm2 = 1'b1;
        tick(1);
        arm2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            q2.push_back(res_t'{16'(dl[i]), ~resp2, 1'b0, 1'b0});
            stim2 = ~stim2;
            tick(dl[i]);
            resp2 = ~resp2;
            tick(2);
            @(negedge clk);
            chk("ar_busy", 32'(busy2), 1);
            tick(1);
        end

        tick(5);
        chk("q1_drained", 32'(q1.size()), 0);
        chk("q2_drained", 32'(q2.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
